// File: rtl/conv5x5_engine_pkg.sv
// Shared constants, FSM encoding and width helper for the 5x5 binary
// convolution engine and its adder tree.
package conv5x5_engine_pkg;

  localparam int IMG_DIM = 28;
  localparam int K       = 5;
  localparam int OUT_DIM = 24;
  localparam int NUM_WT  = 25;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_t;

  // 25 terms of a WT_W-bit signed weight need 5 extra bits of headroom
  function automatic int acc_w_min(input int wt_w);
    return wt_w + 5;
  endfunction

endpackage

// File: rtl/conv5x5_engine_sum.sv
// Combinational 25-term masked adder: sums the weights whose window
// pixel is set, producing a sign-extended window result.
module conv5x5_sum
  import conv5x5_engine_pkg::*;
#(
  parameter int WT_W  = 8,
  parameter int ACC_W = 13
) (
  input  logic [NUM_WT-1:0]      i_win,
  input  logic [NUM_WT*WT_W-1:0] i_wt,
  output logic [ACC_W-1:0]       o_sum
);

  localparam int SUM_W = acc_w_min(WT_W);

  logic signed [SUM_W-1:0] w_acc;

  always_comb begin
    w_acc = '0;
    for (int i = 0; i < NUM_WT; i++) begin
      if (i_win[i]) begin
        w_acc = w_acc
              + SUM_W'($signed(i_wt[i*WT_W +: WT_W]));
      end
    end
  end

  assign o_sum = ACC_W'(w_acc);

endmodule

// File: rtl/conv5x5_engine.sv
// 5x5 binary-image convolution sweep: generates column reads, rebuilds
// each window from returning 5-bit slices and streams tagged sums.
module conv5x5_engine
  import conv5x5_engine_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter int WT_W   = 8,
  parameter int ACC_W  = 13
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cal_start,
  input  logic             wt_wr_en,
  input  logic [4:0]       wt_wr_addr,
  input  logic [WT_W-1:0]  wt_wr_data,
  output logic [4:0]       data_rd_addr,
  output logic [4:0]       conv_row_cnt,
  input  logic [4:0]       col_data,
  output logic [ACC_W-1:0] conv_data,
  output logic             conv_data_vld,
  output logic [4:0]       conv_out_row,
  output logic [4:0]       conv_out_col,
  output logic             busy,
  output logic             conv_done
);

  state_t           r_state;
  logic [4:0]       r_col;
  logic [4:0]       r_row;
  logic             r_busy;
  logic             r_done;
  logic [WT_W-1:0]  r_wt [NUM_WT];
  logic             r_tv [RD_LAT];
  logic [4:0]       r_tr [RD_LAT];
  logic [4:0]       r_tc [RD_LAT];
  logic [4:0]       r_win [K-1];
  logic [ACC_W-1:0] r_data;
  logic             r_vld;
  logic [4:0]       r_orow;
  logic [4:0]       r_ocol;

  logic                  w_issue;
  logic                  w_tv;
  logic [4:0]            w_tr;
  logic [4:0]            w_tc;
  logic                  w_full;
  logic                  w_last;
  logic [NUM_WT-1:0]     w_bits;
  logic [NUM_WT*WT_W-1:0] w_wt;
  logic [ACC_W-1:0]      w_sum;

  assign w_issue = (r_state == S_RUN);
  assign w_tv    = r_tv[RD_LAT-1];
  assign w_tr    = r_tr[RD_LAT-1];
  assign w_tc    = r_tc[RD_LAT-1];
  assign w_full  = w_tv && (w_tc >= 5'(K-1));
  assign w_last  = w_full
                && (w_tr == 5'(OUT_DIM-1))
                && (w_tc == 5'(IMG_DIM-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_col   <= '0;
      r_row   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (cal_start) begin
            r_state <= S_RUN;
            r_col   <= '0;
            r_row   <= '0;
            r_busy  <= 1'b1;
          end
        end
        S_RUN: begin
          if (r_col == 5'(IMG_DIM-1)) begin
            r_col <= '0;
            if (r_row == 5'(OUT_DIM-1)) begin
              r_row   <= '0;
              r_state <= S_DRAIN;
            end else begin
              r_row <= r_row + 5'd1;
            end
          end else begin
            r_col <= r_col + 5'd1;
          end
        end
        S_DRAIN: begin
          if (w_last) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // weights only change between sweeps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_WT; i++) r_wt[i] <= '0;
    end else if (wt_wr_en && (r_state == S_IDLE)
                 && (wt_wr_addr < 5'(NUM_WT))) begin
      r_wt[wt_wr_addr] <= wt_wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) begin
        r_tv[i] <= 1'b0;
        r_tr[i] <= '0;
        r_tc[i] <= '0;
      end
    end else begin
      r_tv[0] <= w_issue;
      r_tr[0] <= r_row;
      r_tc[0] <= r_col;
      for (int i = 1; i < RD_LAT; i++) begin
        r_tv[i] <= r_tv[i-1];
        r_tr[i] <= r_tr[i-1];
        r_tc[i] <= r_tc[i-1];
      end
    end
  end

  // four older columns held; the live col_data is window column 4
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < K-1; j++) r_win[j] <= '0;
    end else if (w_tv) begin
      for (int j = 0; j < K-2; j++) r_win[j] <= r_win[j+1];
      r_win[K-2] <= col_data;
    end
  end

  always_comb begin
    w_bits = '0;
    for (int k = 0; k < K; k++) begin
      for (int j = 0; j < K; j++) begin
        w_bits[k*K+j] = (j == K-1) ? col_data[k]
                                   : r_win[j][k];
      end
    end
  end

  always_comb begin
    w_wt = '0;
    for (int i = 0; i < NUM_WT; i++) begin
      w_wt[i*WT_W +: WT_W] = r_wt[i];
    end
  end

  conv5x5_sum #(
    .WT_W  (WT_W),
    .ACC_W (ACC_W)
  ) u_sum (
    .i_win (w_bits),
    .i_wt  (w_wt),
    .o_sum (w_sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
      r_vld  <= 1'b0;
      r_orow <= '0;
      r_ocol <= '0;
    end else begin
      r_vld <= w_full;
      if (w_full) begin
        r_data <= w_sum;
        r_orow <= w_tr;
        r_ocol <= w_tc - 5'(K-1);
      end
    end
  end

  assign data_rd_addr  = r_col;
  assign conv_row_cnt  = w_tr;
  assign conv_data     = r_data;
  assign conv_data_vld = r_vld;
  assign conv_out_row  = r_orow;
  assign conv_out_col  = r_ocol;
  assign busy          = r_busy;
  assign conv_done     = r_done;

endmodule

// File: tb/tb_conv5x5_engine.sv
// Directed bench for conv5x5_engine: two instances (read latency 1 and 3)
// fed by image RAM models, checked against hand values and a window model.
module tb_conv5x5_engine;

  typedef struct {
    string name;
    int    img_k;
    int    wt_k;
    int    wval;
    int    mode;
    int    expv;
    bit    mid;
  } vec_t;

  localparam int RSENT = 99999;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst_n;
  logic        cal_start;
  logic        wt_wr_en;
  logic [4:0]  wt_wr_addr;
  logic [7:0]  wt_wr_data;

  logic [4:0]  a_addr, a_rcnt, a_col, a_orow, a_ocol;
  logic [12:0] a_data;
  logic        a_vld, a_busy, a_done;
  logic [4:0]  b_addr, b_rcnt, b_col, b_orow, b_ocol;
  logic [12:0] b_data;
  logic        b_vld, b_busy, b_done;

  conv5x5_engine #(.RD_LAT(1), .WT_W(8), .ACC_W(13)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .cal_start(cal_start),
    .wt_wr_en(wt_wr_en), .wt_wr_addr(wt_wr_addr),
    .wt_wr_data(wt_wr_data), .data_rd_addr(a_addr),
    .conv_row_cnt(a_rcnt), .col_data(a_col),
    .conv_data(a_data), .conv_data_vld(a_vld),
    .conv_out_row(a_orow), .conv_out_col(a_ocol),
    .busy(a_busy), .conv_done(a_done)
  );

  conv5x5_engine #(.RD_LAT(3), .WT_W(8), .ACC_W(13)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .cal_start(cal_start),
    .wt_wr_en(wt_wr_en), .wt_wr_addr(wt_wr_addr),
    .wt_wr_data(wt_wr_data), .data_rd_addr(b_addr),
    .conv_row_cnt(b_rcnt), .col_data(b_col),
    .conv_data(b_data), .conv_data_vld(b_vld),
    .conv_out_row(b_orow), .conv_out_col(b_ocol),
    .busy(b_busy), .conv_done(b_done)
  );

  logic [27:0] img [28];
  logic signed [7:0] wm [25];

  // image RAM models: registered column read, row slice by conv_row_cnt
  logic [4:0] a_pipe;
  logic [4:0] b_pipe [3];
  always @(posedge clk) begin
    a_pipe    <= a_addr;
    b_pipe[0] <= b_addr;
    b_pipe[1] <= b_pipe[0];
    b_pipe[2] <= b_pipe[1];
  end

  function automatic logic [4:0] slice(input logic [4:0] r,
                                       input logic [4:0] c);
    logic [4:0] s;
    int idx;
    s = '0;
    for (int k = 0; k < 5; k++) begin
      idx = int'(r) + k;
      if (idx < 28 && c < 5'd28) s[k] = img[idx][c];
    end
    return s;
  endfunction

  always_comb a_col = slice(a_rcnt, a_pipe);
  always_comb b_col = slice(b_rcnt, b_pipe[2]);

  int pass = 0;
  int total = 0;
  int nv[2], first[2], last[2], nd[2], ordbad[2], donebad[2];
  int res[2][576];
  int t0;
  bit done_ok;

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act == exp) pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic mon(input int d, input logic v, input logic dn,
                     input logic [4:0] r, input logic [4:0] c,
                     input logic [12:0] q);
    int idx;
    idx = int'(r) * 24 + int'(c);
    if (v) begin
      if (nv[d] == 0) first[d] = cyc;
      last[d] = cyc;
      if (idx != nv[d] || r > 5'd23 || c > 5'd23) ordbad[d]++;
      if (idx < 576) res[d][idx] = int'($signed(q));
      nv[d]++;
    end
    if (dn) begin
      nd[d]++;
      if (!(v && r == 5'd23 && c == 5'd23)) donebad[d]++;
    end
  endtask

  task automatic clear_stats();
    for (int d = 0; d < 2; d++) begin
      nv[d] = 0; first[d] = -1; last[d] = -1;
      nd[d] = 0; ordbad[d] = 0; donebad[d] = 0;
      for (int i = 0; i < 576; i++) res[d][i] = RSENT;
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    cal_start = 1'b1;
    @(negedge clk);
    cal_start = 1'b0;
    t0 = cyc;
  endtask

  task automatic sweep(input bit mid);
    clear_stats();
    pulse_start();
    done_ok = 1'b0;
    for (int i = 0; i < 800; i++) begin
      mon(0, a_vld, a_done, a_orow, a_ocol, a_data);
      mon(1, b_vld, b_done, b_orow, b_ocol, b_data);
      if (!a_busy && !b_busy) begin
        done_ok = 1'b1;
        break;
      end
      if (mid) begin
        if (i >= 100 && i < 104) begin
          cal_start  = 1'b1;
          wt_wr_en   = 1'b1;
          wt_wr_addr = 5'(i - 100);
          wt_wr_data = 8'h63;
        end else if (i == 104) begin
          cal_start = 1'b0;
          wt_wr_en  = 1'b0;
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic load_wt();
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      wt_wr_en   = 1'b1;
      wt_wr_addr = 5'(i);
      wt_wr_data = (i < 25) ? wm[i] : 8'h55;
    end
    @(negedge clk);
    wt_wr_en = 1'b0;
  endtask

  function automatic int model(int r, int c);
    int s;
    s = 0;
    for (int k = 0; k < 5; k++)
      for (int j = 0; j < 5; j++)
        if (img[r+k][c+j]) s += int'(wm[k*5+j]);
    return s;
  endfunction

  function automatic int expect_at(vec_t v, int r, int c);
    if (v.mode == 0) return v.expv;
    if (v.mode == 1) return (r == 8 && c == 8) ? v.expv : 0;
    return model(r, c);
  endfunction

  task automatic set_img(input int k);
    logic [31:0] h;
    for (int r = 0; r < 28; r++) begin
      h = 32'(r + 1) * 32'h9E3779B1;
      if (k == 0) img[r] = '1;
      else if (k == 1) img[r] = (r == 10) ? 28'(1) << 10 : '0;
      else img[r] = h[31:4] ^ 28'(r * 28'h0123457);
    end
  endtask

  task automatic set_wm(input int k, input int val);
    for (int i = 0; i < 25; i++) begin
      if (k == 0) wm[i] = 8'(val);
      else if (k == 1) wm[i] = (i == 12) ? 8'(val) : 8'sd0;
      else wm[i] = 8'(i - 12);
    end
  endtask

  task automatic run_vec(input vec_t v, input bit load);
    int err, lat, fr, fc, fv;
    string p;
    set_img(v.img_k);
    set_wm(v.wt_k, v.wval);
    if (load) load_wt();
    sweep(v.mid);
    check({v.name, "/end"}, int'(done_ok), 1);
    for (int d = 0; d < 2; d++) begin
      lat = (d == 0) ? 1 : 3;
      p = $sformatf("%s/L%0d", v.name, lat);
      check({p, "/cnt"}, nv[d], 576);
      check({p, "/order"}, ordbad[d], 0);
      check({p, "/ndone"}, nd[d], 1);
      check({p, "/done_pos"}, donebad[d], 0);
      check({p, "/first"}, first[d] - t0, lat + 5);
      check({p, "/last"}, last[d] - t0, lat + 672);
      err = 0; fr = 0; fc = 0; fv = 0;
      for (int r = 0; r < 24; r++)
        for (int c = 0; c < 24; c++)
          if (res[d][r*24+c] != expect_at(v, r, c)) begin
            if (err == 0) begin
              fr = r; fc = c; fv = res[d][r*24+c];
            end
            err++;
          end
      if (err != 0)
        $display("  first bad %s at (%0d,%0d) value %0d", p, fr, fc, fv);
      check({p, "/vals"}, err, 0);
    end
  endtask

  function automatic int outs_nz(input int d);
    if (d == 0)
      return int'(|{a_addr, a_rcnt, a_data, a_vld,
                    a_orow, a_ocol, a_busy, a_done});
    return int'(|{b_addr, b_rcnt, b_data, b_vld,
                  b_orow, b_ocol, b_busy, b_done});
  endfunction

  vec_t vecs[6];
  vec_t v_zero, v_one;
  int hits;

  initial begin
    vecs[0] = '{"ones_w1",    0, 0,    1, 0,    25, 1'b0};
    vecs[1] = '{"spot",       1, 1,    5, 1,     5, 1'b0};
    vecs[2] = '{"ones_wm128", 0, 0, -128, 0, -3200, 1'b0};
    vecs[3] = '{"ones_w127",  0, 0,  127, 0,  3175, 1'b0};
    vecs[4] = '{"rows_ramp",  2, 2,    0, 2,     0, 1'b0};
    vecs[5] = '{"rows_mid",   2, 2,    0, 2,     0, 1'b1};
    v_zero  = '{"after_rst",  0, 0,    0, 0,     0, 1'b0};
    v_one   = '{"reloaded",   0, 0,    1, 0,    25, 1'b0};

    rst_n = 1'b0;
    cal_start = 1'b0;
    wt_wr_en = 1'b0;
    wt_wr_addr = '0;
    wt_wr_data = '0;
    set_img(0);
    set_wm(0, 0);
    repeat (3) @(negedge clk);
    check("reset/L1/outs", outs_nz(0), 0);
    check("reset/L3/outs", outs_nz(1), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(vecs[i], 1'b1);

    // abort a sweep at result 300 with an asynchronous reset
    set_img(0);
    set_wm(0, 1);
    load_wt();
    clear_stats();
    pulse_start();
    for (int i = 0; i < 800 && nv[0] < 300; i++) begin
      mon(0, a_vld, a_done, a_orow, a_ocol, a_data);
      mon(1, b_vld, b_done, b_orow, b_ocol, b_data);
      if (nv[0] < 300) @(negedge clk);
    end
    check("abort/reached300", nv[0], 300);
    #1 rst_n = 1'b0;
    #1;
    check("abort/L1/outs", outs_nz(0), 0);
    check("abort/L3/outs", outs_nz(1), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    hits = 0;
    for (int i = 0; i < 750; i++) begin
      @(negedge clk);
      hits += int'(a_vld) + int'(a_done) + int'(a_busy);
      hits += int'(b_vld) + int'(b_done) + int'(b_busy);
    end
    check("abort/quiet", hits, 0);

    run_vec(v_zero, 1'b0);
    run_vec(v_one, 1'b1);

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
